// File: rtl/xbus_mon_pkg.sv
// Shared types and constants for the XBUS slave monitor: record status codes,
// record field offsets (relative to the end of the address field), the
// size-code decoder and the monitor FSM state type.
package xbus_mon_pkg;

  localparam logic [1:0] ST_OK       = 2'd0;
  localparam logic [1:0] ST_PROT_ERR = 2'd1;
  localparam logic [1:0] ST_TIMEOUT  = 2'd2;

  // Record = addr[ADDR_W] followed by REC_FIXED_W bits of fixed fields.
  localparam int unsigned REC_FIXED_W    = 74;
  localparam int unsigned REC_SIZE_OFS   = 0;
  localparam int unsigned REC_READ_OFS   = 2;
  localparam int unsigned REC_WRITE_OFS  = 3;
  localparam int unsigned REC_STATUS_OFS = 4;
  localparam int unsigned REC_NBYTES_OFS = 6;
  localparam int unsigned REC_DATA_OFS   = 10;

  typedef enum logic {
    IDLE,
    DATA
  } mon_state_e;

  // Size code 0/1/2/3 -> 1/2/4/8 bytes.
  function automatic logic [3:0] size_to_bytes(input logic [1:0] size);
    return 4'd1 << size;
  endfunction

endpackage

// File: rtl/xbus_mon_fifo.sv
// First-word-fall-through FIFO for completed monitor records.
// A push while full is accepted only when a pop happens in the same cycle.
module xbus_mon_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [WIDTH-1:0]             din,
  output logic                         full,
  input  logic                         pop,
  output logic [WIDTH-1:0]             dout,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LVL_W'(DEPTH));
  assign empty   = (level == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // Storage, pointers and occupancy counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/xbus_slave_monitor_pbfm.sv
// XBUS slave monitor: samples the bus passively, flags each address phase
// for the slave driver, assembles completed transfers into records and
// queues them for a valid/ready consumer.
// Optional wait timeout: define XBUS_MON_WAIT_TIMEOUT_EN.
module xbus_slave_monitor_pbfm
  import xbus_mon_pkg::*;
#(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned TIMEOUT_CYC = 256
) (
  input  logic                              sig_clock,
  input  logic                              sig_reset_n,
  input  logic [ADDR_W-1:0]                 sig_addr,
  input  logic [1:0]                        sig_size,
  input  logic                              sig_read,
  input  logic                              sig_write,
  input  logic                              sig_wait,
  input  logic [7:0]                        sig_data,
  output logic                              a_valid,
  output logic [ADDR_W+3:0]                 a_info,
  output logic                              m_valid,
  input  logic                              m_ready,
  output logic [ADDR_W+REC_FIXED_W-1:0]     m_record,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level,
  output logic [7:0]                        drop_cnt,
  output logic                              prot_err
);

  localparam int unsigned REC_W = ADDR_W + REC_FIXED_W;

  mon_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;
  logic              read_q, write_q;
  logic [1:0]        status_q;
  logic [3:0]        nbytes_exp_q;
  logic [3:0]        beat_cnt_q;
  logic [63:0]       data_q;

  logic              capture, beat_ok, push_req;
  logic [1:0]        push_status;
  logic [3:0]        push_nbytes;
  logic [63:0]       push_data;
  logic [REC_W-1:0]  push_rec;
  logic              fifo_full, fifo_empty, fifo_pop;

`ifdef XBUS_MON_WAIT_TIMEOUT_EN
  localparam int unsigned WT_W = $clog2(TIMEOUT_CYC+1);
  logic [WT_W-1:0] wait_cnt_q;

  // Consecutive wait cycles since DATA entry or the last accepted beat.
  always_ff @(posedge sig_clock or negedge sig_reset_n) begin
    if (!sig_reset_n)                        wait_cnt_q <= '0;
    else if (capture || beat_ok)             wait_cnt_q <= '0;
    else if (state_q == DATA && sig_wait)    wait_cnt_q <= wait_cnt_q + WT_W'(1);
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYC == 0);
`endif

  // FSM state register.
  always_ff @(posedge sig_clock or negedge sig_reset_n) begin
    if (!sig_reset_n) state_q <= IDLE;
    else              state_q <= state_d;
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (capture)  state_d = DATA;
      DATA: if (push_req) state_d = IDLE;
      default:            state_d = IDLE;
    endcase
  end

  // FSM outputs: capture/beat/push strobes and the record being pushed,
  // which already contains the byte arriving on the final beat.
  always_comb begin
    capture     = 1'b0;
    beat_ok     = 1'b0;
    push_req    = 1'b0;
    push_status = status_q;
    push_nbytes = beat_cnt_q;
    push_data   = data_q;
    unique case (state_q)
      IDLE: capture = sig_read || sig_write;
      DATA: begin
        if (!sig_wait) begin
          beat_ok = 1'b1;
          push_data[{beat_cnt_q[2:0], 3'b000} +: 8] = sig_data;
          push_nbytes = beat_cnt_q + 4'd1;
          push_req    = (push_nbytes == nbytes_exp_q);
        end
`ifdef XBUS_MON_WAIT_TIMEOUT_EN
        else if (wait_cnt_q == WT_W'(TIMEOUT_CYC - 1)) begin
          push_req    = 1'b1;
          push_status = ST_TIMEOUT;
        end
`endif
      end
      default: ;
    endcase
  end

  // Assemble the record in the fixed field layout.
  always_comb begin
    push_rec = '0;
    push_rec[ADDR_W-1:0]                   = addr_q;
    push_rec[ADDR_W+REC_SIZE_OFS   +: 2]   = size_q;
    push_rec[ADDR_W+REC_READ_OFS]          = read_q;
    push_rec[ADDR_W+REC_WRITE_OFS]         = write_q;
    push_rec[ADDR_W+REC_STATUS_OFS +: 2]   = push_status;
    push_rec[ADDR_W+REC_NBYTES_OFS +: 4]   = push_nbytes;
    push_rec[ADDR_W+REC_DATA_OFS   +: 64]  = push_data;
  end

  // Transfer datapath, address-phase event and sticky protocol error.
  always_ff @(posedge sig_clock or negedge sig_reset_n) begin
    if (!sig_reset_n) begin
      a_valid      <= 1'b0;
      a_info       <= '0;
      addr_q       <= '0;
      size_q       <= '0;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      status_q     <= ST_OK;
      nbytes_exp_q <= '0;
      beat_cnt_q   <= '0;
      data_q       <= '0;
      prot_err     <= 1'b0;
    end else begin
      a_valid <= capture;
      if (capture) begin
        a_info       <= {sig_write, sig_read, sig_size, sig_addr};
        addr_q       <= sig_addr;
        size_q       <= sig_size;
        read_q       <= sig_read;
        write_q      <= sig_write;
        status_q     <= (sig_read && sig_write) ? ST_PROT_ERR : ST_OK;
        nbytes_exp_q <= size_to_bytes(sig_size);
        beat_cnt_q   <= '0;
        data_q       <= '0;
        if (sig_read && sig_write) prot_err <= 1'b1;
      end
      if (beat_ok) begin
        beat_cnt_q <= push_nbytes;
        data_q     <= push_data;
      end
    end
  end

  assign m_valid  = !fifo_empty;
  assign fifo_pop = m_valid && m_ready;

  // Overflow counter: a push is lost only when full with no pop alongside.
  always_ff @(posedge sig_clock or negedge sig_reset_n) begin
    if (!sig_reset_n) drop_cnt <= '0;
    else if (push_req && fifo_full && !fifo_pop && drop_cnt != 8'hFF)
      drop_cnt <= drop_cnt + 8'd1;
  end

  xbus_mon_fifo #(
    .WIDTH (REC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (sig_clock),
    .rst_n (sig_reset_n),
    .push  (push_req),
    .din   (push_rec),
    .full  (fifo_full),
    .pop   (fifo_pop),
    .dout  (m_record),
    .empty (fifo_empty),
    .level (fifo_level)
  );

endmodule

// File: tb/tb_xbus_slave_monitor_pbfm.sv
// Scoreboard bench for xbus_slave_monitor_pbfm: stimulus pushes expected
// records, a monitor compares them as the DUT presents them.
module tb_xbus_slave_monitor_pbfm;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] sig_addr;
  logic [1:0]  sig_size;
  logic        sig_read, sig_write, sig_wait;
  logic [7:0]  sig_data;
  logic        a_valid;
  logic [19:0] a_info;
  logic        m_valid, m_ready;
  logic [89:0] m_record;
  logic [2:0]  fifo_level;
  logic [7:0]  drop_cnt;
  logic        prot_err;

  int          nchk = 0;
  int          errs = 0;
  logic [89:0] sb[$];
  int          mcount = 0;
  int          mdrops = 0;
  logic        exp_push = 1'b0;
  logic [89:0] exp_rec;
  logic        prot_model = 1'b0;
  int          rdy_mode = 1;

  always #5 clk = ~clk;

  xbus_slave_monitor_pbfm #(
    .ADDR_W      (16),
    .FIFO_DEPTH  (DEPTH),
    .TIMEOUT_CYC (8)
  ) dut (
    .sig_clock   (clk),
    .sig_reset_n (rst_n),
    .sig_addr    (sig_addr),
    .sig_size    (sig_size),
    .sig_read    (sig_read),
    .sig_write   (sig_write),
    .sig_wait    (sig_wait),
    .sig_data    (sig_data),
    .a_valid     (a_valid),
    .a_info      (a_info),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_record    (m_record),
    .fifo_level  (fifo_level),
    .drop_cnt    (drop_cnt),
    .prot_err    (prot_err)
  );

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    nchk++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Expected record straight from the field layout: only the first n bytes kept.
  function automatic logic [89:0] mk_rec(input logic r, input logic w, input logic [1:0] sz,
                                         input logic [15:0] a, input logic [63:0] d,
                                         input int n, input logic [1:0] st);
    logic [63:0] kept;
    kept = '0;
    for (int i = 0; i < n; i++) kept[i*8 +: 8] = d[i*8 +: 8];
    return {kept, 4'(n), st, w, r, sz, a};
  endfunction

  // Consumer ready generator: 0 = held low, 1 = held high, 2 = random.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       m_ready = 1'b0;
      1:       m_ready = 1'b1;
      default: m_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Queue-level FIFO model: decides acceptance/drop of each expected record.
  always @(posedge clk or negedge rst_n) begin : mdl
    bit pop;
    bit acc;
    if (!rst_n) begin
      sb.delete();
      mcount = 0;
      mdrops = 0;
    end else begin
      pop = (mcount > 0) && m_ready;
      acc = 1'b0;
      if (exp_push) begin
        if (mcount < DEPTH || pop) begin
          sb.push_back(exp_rec);
          acc = 1'b1;
        end else if (mdrops < 255) begin
          mdrops++;
        end
      end
      mcount = mcount + int'(acc) - int'(pop);
    end
  end

  // Monitor: compares occupancy, drops, sticky error and the head record.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("fifo_level", 128'(fifo_level), 128'(mcount));
      chk("drop_cnt", 128'(drop_cnt), 128'(mdrops));
      chk("m_valid", 128'(m_valid), 128'(mcount > 0));
      chk("prot_err", 128'(prot_err), 128'(prot_model));
      if (m_valid) begin
        if (sb.size() == 0) begin
          nchk++;
          errs++;
          $display("FAIL m_record: got %0h expected no record", m_record);
        end else begin
          chk("m_record", 128'(m_record), 128'(sb[0]));
          if (m_ready) void'(sb.pop_front());
        end
      end
    end
  end

  // One bus transfer; wp holds the wait cycles before each beat, 4 bits per beat.
  task automatic xfer(input logic r, input logic w, input logic [1:0] sz, input logic [15:0] a,
                      input logic [63:0] d, input logic [31:0] wp);
    int n;
    bit lo;
    n  = 1 << sz;
    lo = 1'b1;
    sig_read = r; sig_write = w; sig_size = sz; sig_addr = a;
    sig_wait = 1'($urandom_range(0, 1)); sig_data = 8'($urandom);
    @(posedge clk); #1;
    sig_read = 1'b0; sig_write = 1'b0;
    sig_addr = 16'($urandom); sig_size = 2'($urandom);
    if (r && w) prot_model = 1'b1;
    chk("a_valid_pulse", 128'(a_valid), 128'(1));
    chk("a_info", 128'(a_info), 128'({w, r, sz, a}));
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < int'(wp[i*4 +: 4]); k++) begin
        sig_wait = 1'b1; sig_data = 8'($urandom);
        @(posedge clk); #1;
        if (lo) begin chk("a_valid_low", 128'(a_valid), 128'(0)); lo = 1'b0; end
      end
      sig_wait = 1'b0; sig_data = d[i*8 +: 8];
      if (i == n - 1) begin
        exp_rec  = mk_rec(r, w, sz, a, d, n, (r && w) ? 2'd1 : 2'd0);
        exp_push = 1'b1;
      end
      @(posedge clk); #1;
      exp_push = 1'b0;
      if (lo) begin chk("a_valid_low", 128'(a_valid), 128'(0)); lo = 1'b0; end
    end
    sig_wait = 1'($urandom_range(0, 1)); sig_data = 8'($urandom);
  endtask

  task automatic idle(input int c);
    for (int i = 0; i < c; i++) begin @(posedge clk); #1; end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (mcount != 0 && t < 400) begin @(posedge clk); t++; end
    @(posedge clk); #1;
    if (t >= 400) begin
      nchk++; errs++;
      $display("FAIL drain_timeout: level %0d expected 0", fifo_level);
    end
    chk("drain_level", 128'(fifo_level), 128'(0));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_a_valid"},  128'(a_valid), 128'(0));
    chk({tag, "_a_info"},   128'(a_info), 128'(0));
    chk({tag, "_m_valid"},  128'(m_valid), 128'(0));
    chk({tag, "_m_record"}, 128'(m_record), 128'(0));
    chk({tag, "_level"},    128'(fifo_level), 128'(0));
    chk({tag, "_drop"},     128'(drop_cnt), 128'(0));
    chk({tag, "_prot"},     128'(prot_err), 128'(0));
  endtask

  initial begin : watchdog
    #2ms;
    errs++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] rd;
    int          k;
    rst_n = 1'b0;
    sig_addr = '0; sig_size = '0; sig_read = 1'b0; sig_write = 1'b0;
    sig_wait = 1'b1; sig_data = '0; m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;
    idle(1);

    // Write, 4 bytes, no wait.
    xfer(1'b0, 1'b1, 2'd2, 16'h1234, 64'h0000_0000_A3A2_A1A0, 32'h0);
    // Read, 8 bytes, 3 wait cycles before the third beat.
    xfer(1'b1, 1'b0, 2'd3, 16'hFFFE, 64'hB7B6_B5B4_B3B2_B1B0, 32'h0000_0300);
    // Read and write together: protocol error, still a normal transfer.
    xfer(1'b1, 1'b1, 2'd0, 16'h0042, 64'h5A, 32'h0);
    chk("prot_err_set", 128'(prot_err), 128'(1));
    idle(2);
    drain();

    // Reset in the middle of the data phase.
    sig_read = 1'b1; sig_size = 2'd3; sig_addr = 16'hBEEF;
    @(posedge clk); #1;
    sig_read = 1'b0; sig_wait = 1'b0; sig_data = 8'h11;
    @(posedge clk); #1;
    sig_data = 8'h22;
    @(posedge clk); #1;
    sig_wait = 1'b1;
    rst_n = 1'b0;
    prot_model = 1'b0;
    #2;
    chk_all_zero("midreset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2);
    chk("midreset_no_rec", 128'(fifo_level), 128'(0));
    xfer(1'b0, 1'b1, 2'd1, 16'h0F0F, 64'h0000_0000_0000_C1C0, 32'h0000_0010);
    drain();

    // Overflow: consumer stalled, six single-byte transfers.
    rdy_mode = 0;
    idle(1);
    for (int i = 0; i < 6; i++)
      xfer(1'b1, 1'b0, 2'd0, 16'(16'h0100 + i), 64'(8'h60 + i), 32'h0);
    idle(2);
    chk("ovf_level", 128'(fifo_level), 128'(4));
    chk("ovf_drop", 128'(drop_cnt), 128'(2));
    rdy_mode = 1;
    drain();

`ifdef XBUS_MON_WAIT_TIMEOUT_EN
    // Timeout: one beat of a 4-byte transfer, then wait held.
    sig_write = 1'b1; sig_size = 2'd2; sig_addr = 16'h7777;
    @(posedge clk); #1;
    sig_write = 1'b0; sig_wait = 1'b0; sig_data = 8'h99;
    @(posedge clk); #1;
    sig_wait = 1'b1;
    idle(7);
    exp_rec  = mk_rec(1'b0, 1'b1, 2'd2, 16'h7777, 64'h99, 1, 2'd2);
    exp_push = 1'b1;
    @(posedge clk); #1;
    exp_push = 1'b0;
    drain();
`endif

    // Randomised traffic with a random consumer.
    rdy_mode = 2;
    for (int t = 0; t < 60; t++) begin
      logic        rr, ww;
      logic [31:0] wp;
      k  = $urandom_range(0, 9);
      rr = (k < 5);
      ww = (k == 0) || (k >= 5);
      rd = {$urandom, $urandom};
      wp = '0;
      for (int b = 0; b < 8; b++)
        if ($urandom_range(0, 3) == 0) wp[b*4 +: 4] = 4'($urandom_range(1, 3));
      xfer(rr, ww, 2'($urandom_range(0, 3)), 16'($urandom), rd, wp);
      idle($urandom_range(0, 2));
    end
    rdy_mode = 1;
    drain();

    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end

endmodule
